// File: rtl/bp_me_stream_pump_out.sv
`default_nettype none
// ============================================================================
//  Module      : bp_me_stream_pump_out
//  Description : Outbound stream pump. Accepts header/data beats from a cache
//                or CCE FSM and drives them onto an outbound BedRock stream
//                channel through a two-entry output FIFO. Generates per-beat
//                wrapped counts and addresses, last/new/done flags. Supports
//                three modes, chosen per msg_type by the two stream masks:
//                  1:1  both masks set (or neither) - beat in, beat out
//                  1:N  mem mask only - one held FSM beat is replicated
//                  N:1  fsm mask only - non-last FSM beats are dropped
//  Header layout (self-contained BedRock subset, LSB first):
//                  [PADDR_WIDTH-1:0]    addr
//                  [+:3]                size (payload = 2**size bytes)
//                  [+:4]                msg_type
//  Ports       : clk_i, reset_i                 clock, sync active-high reset
//                fsm_base_header_i/data_i/v_i   FSM beat in (header held)
//                fsm_ready_and_o                FSM beat accepted
//                fsm_addr_o/cnt_o               wrapped address / beat index
//                fsm_new_o/last_o/done_o        message boundary flags
//                mem_header_o/data_o/v_o/last_o stream out (FIFO head)
//                mem_ready_and_i                downstream ready
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_me_stream_pump_out #(
    parameter int          PADDR_WIDTH       = 40,
    parameter int          STREAM_DATA_WIDTH = 64,
    parameter int          BLOCK_WIDTH       = 512,
    parameter logic [15:0] MEM_STREAM_MASK   = 16'h0000,
    parameter logic [15:0] FSM_STREAM_MASK   = MEM_STREAM_MASK,
    localparam int c_header_width   = PADDR_WIDTH + 3 + 4,
    localparam int c_stream_words   = BLOCK_WIDTH / STREAM_DATA_WIDTH,
    localparam int c_data_len_width = (c_stream_words > 1) ? $clog2(c_stream_words) : 1,
    localparam int c_beat_bytes     = STREAM_DATA_WIDTH / 8,
    localparam int c_offset_width   = (c_beat_bytes > 1) ? $clog2(c_beat_bytes) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [c_header_width-1:0]    fsm_base_header_i,
    input  logic [STREAM_DATA_WIDTH-1:0] fsm_data_i,
    input  logic                         fsm_v_i,
    output logic                         fsm_ready_and_o,
    output logic [PADDR_WIDTH-1:0]       fsm_addr_o,
    output logic [c_data_len_width-1:0]  fsm_cnt_o,
    output logic                         fsm_new_o,
    output logic                         fsm_last_o,
    output logic                         fsm_done_o,
    output logic [c_header_width-1:0]    mem_header_o,
    output logic [STREAM_DATA_WIDTH-1:0] mem_data_o,
    output logic                         mem_v_o,
    output logic                         mem_last_o,
    input  logic                         mem_ready_and_i
);

    localparam int c_fifo_width = 1 + c_header_width + STREAM_DATA_WIDTH;

    logic [PADDR_WIDTH-1:0] w_addr;
    logic [2:0]             w_size;
    logic [3:0]             w_msg_type;

    assign w_addr     = fsm_base_header_i[PADDR_WIDTH-1:0];
    assign w_size     = fsm_base_header_i[PADDR_WIDTH +: 3];
    assign w_msg_type = fsm_base_header_i[PADDR_WIDTH+3 +: 4];

    logic w_fsm_stream, w_mem_stream;
    logic w_adv;
    logic w_fifo_ready;

    // ------------------------------------------------------------------
    // Beat counter, wrapped address and message-boundary flags
    // ------------------------------------------------------------------
    generate
        if (c_stream_words > 1) begin : g_multi
            logic                        r_streaming;
            logic [c_data_len_width-1:0] r_cnt;
            logic [31:0]                 w_words;
            logic [c_data_len_width-1:0] w_num_stream;
            logic [c_data_len_width-1:0] w_first_cnt, w_last_cnt, w_stream_cnt;
            logic [c_data_len_width-1:0] w_sel_mask, w_wrap_idx;
            logic                        w_multi;

            // Payload beats; sub-beat sizes still take one beat. A full
            // block truncates to zero, which makes last = first-1 and the
            // select mask all ones, i.e. the whole window.
            assign w_words      = (32'(1) << w_size) >> $clog2(c_beat_bytes);
            assign w_num_stream = (w_words == 32'd0) ? c_data_len_width'(1)
                                                     : w_words[c_data_len_width-1:0];
            assign w_first_cnt  = w_addr[c_offset_width +: c_data_len_width];
            assign w_last_cnt   = w_first_cnt + w_num_stream - c_data_len_width'(1);
            assign w_multi      = (w_first_cnt != w_last_cnt);

            assign w_fsm_stream = FSM_STREAM_MASK[w_msg_type] & w_multi;
            assign w_mem_stream = MEM_STREAM_MASK[w_msg_type] & w_multi;

            assign w_stream_cnt = r_streaming ? r_cnt : w_first_cnt;

            // Counter bits inside the message window, address bits outside
            assign w_sel_mask = w_num_stream - c_data_len_width'(1);
            assign w_wrap_idx = (w_stream_cnt & w_sel_mask) | (w_first_cnt & ~w_sel_mask);

            always_comb begin
                fsm_addr_o = w_addr;
                fsm_addr_o[c_offset_width +: c_data_len_width] = w_wrap_idx;
            end

            assign fsm_cnt_o  = w_wrap_idx;
            assign fsm_last_o = ~(w_fsm_stream | w_mem_stream) | (w_stream_cnt == w_last_cnt);
            assign fsm_new_o  = (w_fsm_stream | w_mem_stream) & ~r_streaming;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_streaming <= 1'b0;
                    r_cnt       <= '0;
                end else begin
                    // Done takes priority so back-to-back messages restart
                    // from their own first_cnt with no bubble.
                    if (fsm_done_o)
                        r_streaming <= 1'b0;
                    else if (w_adv & ~fsm_last_o)
                        r_streaming <= 1'b1;
                    if (w_adv)
                        r_cnt <= w_stream_cnt + c_data_len_width'(1);
                end
            end
        end else begin : g_single
            assign w_fsm_stream = 1'b0;
            assign w_mem_stream = 1'b0;
            assign fsm_addr_o   = w_addr;
            assign fsm_cnt_o    = '0;
            assign fsm_last_o   = 1'b1;
            assign fsm_new_o    = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Mode selection and handshakes
    // ------------------------------------------------------------------
    logic w_one_to_n, w_n_to_one;
    logic w_fifo_v_in, w_enq, w_fsm_hs;

    assign w_one_to_n = w_mem_stream & ~w_fsm_stream;
    assign w_n_to_one = w_fsm_stream & ~w_mem_stream;

    // N:1 only forwards the final beat; the rest are swallowed.
    assign w_fifo_v_in = fsm_v_i & (~w_n_to_one | fsm_last_o);
    assign w_enq       = w_fifo_v_in & w_fifo_ready;

    always_comb begin
        fsm_ready_and_o = w_fifo_ready;
        if (w_n_to_one)
            fsm_ready_and_o = ~fsm_last_o | w_fifo_ready;
        else if (w_one_to_n)
            fsm_ready_and_o = w_fifo_ready & fsm_last_o;
    end

    assign w_fsm_hs   = fsm_v_i & fsm_ready_and_o;
    // 1:N counts replicated enqueues; otherwise the counter follows FSM beats.
    assign w_adv      = w_one_to_n ? w_enq : w_fsm_hs;
    assign fsm_done_o = fsm_last_o & w_fsm_hs;

    // ------------------------------------------------------------------
    // Two-entry output FIFO of {last, header, data}
    // ------------------------------------------------------------------
    logic [c_fifo_width-1:0] r_mem [2];
    logic                    r_wptr, r_rptr;
    logic [1:0]              r_count;
    logic                    w_deq;

    assign w_fifo_ready = (r_count != 2'd2);
    assign mem_v_o      = (r_count != 2'd0);
    assign w_deq        = mem_v_o & mem_ready_and_i;

    assign {mem_last_o, mem_header_o, mem_data_o} = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq)
                r_wptr <= ~r_wptr;
            if (w_deq)
                r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq)
            r_mem[r_wptr] <= {fsm_last_o, fsm_base_header_i, fsm_data_i};
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_me_stream_pump_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_me_stream_pump_out
//  Description : Directed self-checking bench for bp_me_stream_pump_out.
//                msg_type 0 = 1:1, 1 = 1:N, 2 = N:1, 3 = single beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_me_stream_pump_out;

    localparam int c_hw = 47;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [c_hw-1:0]   fsm_base_header_i;
    logic [63:0]       fsm_data_i;
    logic              fsm_v_i;
    logic              fsm_ready_and_o;
    logic [39:0]       fsm_addr_o;
    logic [2:0]        fsm_cnt_o;
    logic              fsm_new_o, fsm_last_o, fsm_done_o;
    logic [c_hw-1:0]   mem_header_o;
    logic [63:0]       mem_data_o;
    logic              mem_v_o, mem_last_o;
    logic              mem_ready_and_i;

    int n_checks = 0;
    int n_errors = 0;

    bp_me_stream_pump_out #(
        .PADDR_WIDTH      (40),
        .STREAM_DATA_WIDTH(64),
        .BLOCK_WIDTH      (512),
        .MEM_STREAM_MASK  (16'h0003),
        .FSM_STREAM_MASK  (16'h0005)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .fsm_base_header_i(fsm_base_header_i),
        .fsm_data_i       (fsm_data_i),
        .fsm_v_i          (fsm_v_i),
        .fsm_ready_and_o  (fsm_ready_and_o),
        .fsm_addr_o       (fsm_addr_o),
        .fsm_cnt_o        (fsm_cnt_o),
        .fsm_new_o        (fsm_new_o),
        .fsm_last_o       (fsm_last_o),
        .fsm_done_o       (fsm_done_o),
        .mem_header_o     (mem_header_o),
        .mem_data_o       (mem_data_o),
        .mem_v_o          (mem_v_o),
        .mem_last_o       (mem_last_o),
        .mem_ready_and_i  (mem_ready_and_i)
    );

    always #5 clk = ~clk;

    function automatic logic [c_hw-1:0] hdr(input logic [3:0] t, input logic [2:0] s,
                                             input logic [39:0] a);
        return {t, s, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] q[$];
        logic        exp_rdy, hs, deq;
        int          sent, recv;

        reset_i           = 1'b1;
        fsm_v_i           = 1'b0;
        fsm_data_i        = '0;
        fsm_base_header_i = hdr(4'd3, 3'd3, 40'h0);
        mem_ready_and_i   = 1'b1;
        step; step;
        reset_i = 1'b0;
        check("rst_mem_v", 64'(mem_v_o), 64'd0);
        step;
        check("rst_ready", 64'(fsm_ready_and_o), 64'd1);
        check("rst_mem_v2", 64'(mem_v_o), 64'd0);
        check("rst_new", 64'(fsm_new_o), 64'd0);

        // 1:1, 64B at 0x80000010: critical word first, wrap 6,7,0,1
        fsm_base_header_i = hdr(4'd0, 3'd6, 40'h80000010);
        for (int k = 0; k < 8; k++) begin
            fsm_v_i    = 1'b1;
            fsm_data_i = 64'h1100 + 64'(k);
            #1;
            check($sformatf("t1_addr%0d", k), 64'(fsm_addr_o), 64'h80000000 + 64'(((2 + k) % 8) * 8));
            check($sformatf("t1_cnt%0d", k), 64'(fsm_cnt_o), 64'((2 + k) % 8));
            check($sformatf("t1_rdy%0d", k), 64'(fsm_ready_and_o), 64'd1);
            check($sformatf("t1_last%0d", k), 64'(fsm_last_o), 64'(k == 7));
            check($sformatf("t1_new%0d", k), 64'(fsm_new_o), 64'(k == 0));
            check($sformatf("t1_done%0d", k), 64'(fsm_done_o), 64'(k == 7));
            step;
            check($sformatf("t1_mv%0d", k), 64'(mem_v_o), 64'd1);
            check($sformatf("t1_md%0d", k), mem_data_o, 64'h1100 + 64'(k));
            check($sformatf("t1_ml%0d", k), 64'(mem_last_o), 64'(k == 7));
            check($sformatf("t1_hdr%0d", k), 64'(mem_header_o[39:0]), 64'h80000010);
        end
        fsm_v_i = 1'b0;
        step;
        check("t1_idle", 64'(mem_v_o), 64'd0);

        // 1:N, 32B at 0x28: one held beat replicated 4 times
        fsm_base_header_i = hdr(4'd1, 3'd5, 40'h28);
        fsm_data_i        = 64'hDEAD;
        fsm_v_i           = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic [39:0] exp_a;
            case (c)
                0: exp_a = 40'h28;
                1: exp_a = 40'h30;
                2: exp_a = 40'h38;
                default: exp_a = 40'h20;
            endcase
            #1;
            check($sformatf("t2_addr%0d", c), 64'(fsm_addr_o), 64'(exp_a));
            check($sformatf("t2_rdy%0d", c), 64'(fsm_ready_and_o), 64'(c == 3));
            check($sformatf("t2_last%0d", c), 64'(fsm_last_o), 64'(c == 3));
            check($sformatf("t2_new%0d", c), 64'(fsm_new_o), 64'(c == 0));
            check($sformatf("t2_done%0d", c), 64'(fsm_done_o), 64'(c == 3));
            step;
            check($sformatf("t2_mv%0d", c), 64'(mem_v_o), 64'd1);
            check($sformatf("t2_md%0d", c), mem_data_o, 64'hDEAD);
            check($sformatf("t2_ml%0d", c), 64'(mem_last_o), 64'(c == 3));
        end
        fsm_v_i = 1'b0;
        step;
        check("t2_idle", 64'(mem_v_o), 64'd0);

        // N:1, 8 FSM beats collapse into one stream beat
        fsm_base_header_i = hdr(4'd2, 3'd6, 40'h0);
        for (int k = 0; k < 8; k++) begin
            fsm_v_i    = 1'b1;
            fsm_data_i = 64'hA0 + 64'(k);
            #1;
            check($sformatf("t3_rdy%0d", k), 64'(fsm_ready_and_o), 64'd1);
            check($sformatf("t3_last%0d", k), 64'(fsm_last_o), 64'(k == 7));
            check($sformatf("t3_done%0d", k), 64'(fsm_done_o), 64'(k == 7));
            step;
            check($sformatf("t3_mv%0d", k), 64'(mem_v_o), 64'(k == 7));
        end
        check("t3_md", mem_data_o, 64'hA7);
        check("t3_ml", 64'(mem_last_o), 64'd1);
        fsm_v_i = 1'b0;
        step;
        check("t3_idle", 64'(mem_v_o), 64'd0);

        // Single-beat 8B uncached write
        fsm_base_header_i = hdr(4'd3, 3'd3, 40'h1008);
        fsm_data_i        = 64'h5555;
        fsm_v_i           = 1'b1;
        #1;
        check("t4_last", 64'(fsm_last_o), 64'd1);
        check("t4_new", 64'(fsm_new_o), 64'd0);
        check("t4_done", 64'(fsm_done_o), 64'd1);
        check("t4_addr", 64'(fsm_addr_o), 64'h1008);
        step;
        fsm_v_i = 1'b0;
        check("t4_mv", 64'(mem_v_o), 64'd1);
        check("t4_ml", 64'(mem_last_o), 64'd1);
        check("t4_md", mem_data_o, 64'h5555);
        step;
        check("t4_idle", 64'(mem_v_o), 64'd0);

        // Backpressure: mem ready toggling, two-entry FIFO model
        fsm_base_header_i = hdr(4'd0, 3'd6, 40'h0);
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            mem_ready_and_i = (cyc % 2 == 0);
            fsm_v_i         = (sent < 8);
            fsm_data_i      = 64'h7700 + 64'(sent);
            #1;
            exp_rdy = (q.size() < 2);
            check($sformatf("t5_rdy%0d", cyc), 64'(fsm_ready_and_o), 64'(exp_rdy));
            check($sformatf("t5_mv%0d", cyc), 64'(mem_v_o), 64'(q.size() > 0));
            if (q.size() > 0) begin
                check($sformatf("t5_md%0d", cyc), mem_data_o, q[0]);
                check($sformatf("t5_ml%0d", cyc), 64'(mem_last_o), 64'(q[0] == 64'h7707));
            end
            hs  = fsm_v_i & exp_rdy;
            deq = (q.size() > 0) & mem_ready_and_i;
            @(posedge clk);
            if (deq) begin
                void'(q.pop_front());
                recv++;
            end
            if (hs) begin
                q.push_back(64'h7700 + 64'(sent));
                sent++;
            end
            #1;
        end
        check("t5_all_beats", 64'(recv), 64'd8);
        fsm_v_i         = 1'b0;
        mem_ready_and_i = 1'b1;
        step;
        check("t5_idle", 64'(mem_v_o), 64'd0);

        // Reset in the middle of a 64B message, then a 16B message at 0x38
        fsm_base_header_i = hdr(4'd0, 3'd6, 40'h0);
        for (int k = 0; k < 3; k++) begin
            fsm_v_i    = 1'b1;
            fsm_data_i = 64'(k);
            step;
        end
        fsm_v_i = 1'b0;
        reset_i = 1'b1;
        step;
        reset_i = 1'b0;
        check("t6_flush", 64'(mem_v_o), 64'd0);
        fsm_base_header_i = hdr(4'd0, 3'd4, 40'h38);
        fsm_v_i           = 1'b1;
        fsm_data_i        = 64'hB0;
        #1;
        check("t6_addr0", 64'(fsm_addr_o), 64'h38);
        check("t6_cnt0", 64'(fsm_cnt_o), 64'd7);
        check("t6_new0", 64'(fsm_new_o), 64'd1);
        check("t6_last0", 64'(fsm_last_o), 64'd0);
        step;
        check("t6_mv0", 64'(mem_v_o), 64'd1);
        check("t6_md0", mem_data_o, 64'hB0);
        check("t6_ml0", 64'(mem_last_o), 64'd0);
        fsm_data_i = 64'hB1;
        #1;
        check("t6_addr1", 64'(fsm_addr_o), 64'h30);
        check("t6_new1", 64'(fsm_new_o), 64'd0);
        check("t6_last1", 64'(fsm_last_o), 64'd1);
        check("t6_done1", 64'(fsm_done_o), 64'd1);
        step;
        fsm_v_i = 1'b0;
        check("t6_md1", mem_data_o, 64'hB1);
        check("t6_ml1", 64'(mem_last_o), 64'd1);
        step;
        check("t6_idle", 64'(mem_v_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_me_stream_pump_out.md
# bp_me_stream_pump_out

Outbound companion to the inbound stream pump. It accepts header and data beats from a cache or CCE FSM and drives them onto an outbound BedRock Stream channel. It generates per-beat counts, wrap-around addresses and last-beat flags, and expands single-beat FSM messages into multi-beat streams where required. It sits between the producing FSM and the memory/network stream link, directly upstream of a downstream inbound stream pump.

## Interface

Parameters:
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p.
- stream_data_width_p, dword_width_gp: beat width in bits.
- block_width_p, cce_block_width_p: maximum message payload in bits; multiple of stream_data_width_p and ≥ it.
- mem_stream_mask_p, 0: bitmask over msg_type; set bits may be multi-beat on the stream output.
- fsm_stream_mask_p, mem_stream_mask_p: bitmask over msg_type; set bits may be multi-beat on the FSM input.
- Derived values:
  - stream_words_lp = block_width_p/stream_data_width_p.
  - data_len_width_lp = safe clog2(stream_words_lp).
  - stream_offset_width_lp = safe clog2(stream_data_width_p/8).

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: synchronous, active-high reset.
- fsm_base_header_i, in, xce_mem_msg_header_width_lp: message header. Held stable by the FSM for every beat of the message.
- fsm_data_i, in, stream_data_width_p: beat data.
- fsm_v_i, in, 1: FSM beat valid.
- fsm_ready_and_o, out, 1: beat accepted when fsm_v_i & fsm_ready_and_o.
- fsm_addr_o, out, paddr_width_p: wrap-around address of the current beat.
- fsm_cnt_o, out, data_len_width_lp: current wrapped beat index.
- fsm_new_o, out, 1: first beat of a multi-beat message is current.
- fsm_last_o, out, 1: current beat is the final beat of its message.
- fsm_done_o, out, 1: final beat handshaken this cycle.
- mem_header_o, out, xce_mem_msg_header_width_lp: stream header.
- mem_data_o, out, stream_data_width_p: stream data.
- mem_v_o, out, 1: stream beat valid.
- mem_last_o, out, 1: final stream beat.
- mem_ready_and_i, in, 1: downstream ready.

## Operation

- Output path is a bsg_two_fifo of {last, header, data}. mem_* outputs come straight from the FIFO head.
- Beat count:
  - num_stream = max((1<<size)/(stream_data_width_p/8), 1), truncated to data_len_width_lp bits.
  - first_cnt = addr[stream_offset_width_lp +: data_len_width_lp].
  - last_cnt = first_cnt + num_stream - 1, modulo 2^data_len_width_lp.
- A message type is streaming on a side iff its mask bit is set and first_cnt ≠ last_cnt.
- stream_cnt = first_cnt when not streaming_r, otherwise the counter value.
- Address generation:
  - sel_mask = num_stream-1.
  - Wrapped index = bitwise mux: stream_cnt where sel_mask=1, original addr bit where sel_mask=0.
  - fsm_addr_o = {upper addr, wrapped index, low stream offset}.
- Enqueued header is fsm_base_header_i unchanged, so the addr field keeps the critical-word address on every beat.
- streaming_r: set on any non-last handshake, cleared on fsm_done_o. Clear wins over set.
- Mode 1:1 (both masks set, or neither):
  - fsm_ready_and_o = fifo ready.
  - Each FSM beat enqueues one beat with last = fsm_last_o.
  - The counter increments per beat.
- Mode 1:N (mem mask set, fsm mask clear):
  - The FSM presents one beat and holds it.
  - The pump enqueues one beat per cycle while the FIFO is ready, replicating fsm_data_i.
  - fsm_ready_and_o = fifo ready & fsm_last_o.
  - Only the final replicated beat completes the FSM handshake.
- Mode N:1 (fsm mask set, mem mask clear):
  - fsm_ready_and_o is high for non-last beats regardless of FIFO state; these beats are dropped.
  - The last beat is accepted only when the FIFO is ready and enqueues one beat with last=1.
- fsm_new_o = streaming-type & ~streaming_r.
- fsm_done_o = fsm_last_o & enqueue-handshake-of-final-beat. In N:1, fsm_done_o also requires the FIFO to be ready.
- If stream_words_lp == 1: the counter logic is removed, fsm_last_o=1, fsm_new_o=0, fsm_addr_o = header addr.

## Timing

- Reset values: mem_v_o=0, streaming_r=0, counter=0.
  - fsm_ready_and_o=1 after the first post-reset cycle.
  - fsm_new_o and fsm_last_o are combinational from fsm_base_header_i.
- FSM-to-mem latency is 1 cycle: a beat accepted in cycle t appears on mem_v_o in cycle t+1 when the FIFO was empty.
- Throughput is one beat per cycle with mem_ready_and_i held high.
- Backpressure: when the FIFO is full, fsm_ready_and_o=0 (except dropped N:1 beats). FSM data must be held.
- Counter wrap: the index wraps modulo num_stream within the block-aligned window, e.g. 6,7,0,1,...,5.
- Simultaneous done and new (back-to-back messages): the next message's first beat sees streaming_r=0 in the following cycle. There are no bubbles.
- Reset mid-message: the FIFO is flushed and the counter and streaming_r are cleared. The partial stream is abandoned, and no last beat is generated.

## Test plan

- 512b block, 64b beats, 1:1, size=64B, addr 0x80000010 -> 8 mem beats; fsm_addr_o offsets 0x10,0x18,0x20,...,0x38,0x00,0x08; mem_last_o only on beat 8; header addr stays 0x80000010.
- 1:N read of size=32B, addr 0x28 -> 4 replicated beats, wrapped addresses 0x28,0x30,0x38,0x20; fsm_ready_and_o high only in the 4th cycle.
- N:1 with 8 FSM beats -> exactly one mem beat, carrying beat-8 data, with last=1; the first 7 beats are accepted in 7 consecutive cycles.
- Single-beat 8B uncached write -> 1 beat, last=1, fsm_new_o=0, fsm_done_o on the handshake cycle.
- mem_ready_and_i toggling 1010... during a 64B message -> no beats lost or duplicated; fsm_ready_and_o low whenever the FIFO holds 2 entries.
- Assert reset_i at beat 3 of 8, then send a new 16B message -> mem_v_o=0 the cycle after reset; the new message emits 2 beats with a correct first_cnt.
